apu_sound_player: RTL and testbench

- Consumer end of the APU trigger interface. Takes the eat/die/hit sound request levels and plays a fixed four-note square-wave jingle for each on a 1-bit audio pin.
- Notes advance on frame_end.
- Sits between the trigger block and the top-level audio output.

---
 rtl/apu_sound_player.sv | 110 +++++++++++
 tb/tb_apu_sound_player.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/apu_sound_player.sv
// apu_sound_player: plays a fixed four-note square-wave jingle per eat/hit/die request.
// Notes advance on frame_end; a strictly higher-priority request preempts the current jingle.
module apu_sound_player #(
    parameter int NOTE_FRAMES = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic       eat_sound,
    input  logic       die_sound,
    input  logic       hit_sound,
    output logic       sound_out,
    output logic       busy,
    output logic [1:0] sound_id
);
    localparam int FW = NOTE_FRAMES > 1 ? $clog2(NOTE_FRAMES) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(NOTE_FRAMES - 1);
    logic [0:0]       r_state;
    logic [1:0]       r_id;
    logic [1:0]       r_note;
    logic [FW-1:0]    r_frame;
    logic [CNT_W-1:0] r_tone;
    logic             r_out;
    logic             r_eat_q;
    logic             r_die_q;
    logic             r_hit_q;
    logic [CNT_W-1:0] w_half;
    logic [1:0]       w_new_id;
    logic             w_start;
    logic             w_rest;
    logic             w_adv;
    assign w_new_id = (die_sound & ~r_die_q) ? 2'd3 :
                      (hit_sound & ~r_hit_q) ? 2'd2 :
                      (eat_sound & ~r_eat_q) ? 2'd1 : 2'd0;
    assign w_start  = w_new_id > r_id;
    assign w_rest   = w_half == '0;
    assign w_adv    = (r_state == PLAY) && frame_end && (r_frame == LAST_FRAME);
    assign busy      = r_state == PLAY;
    assign sound_id  = r_id;
    assign sound_out = r_out & ~w_rest;
    always_comb begin
        case ({r_id, r_note})
            4'b01_00: w_half = CNT_W'(24068);
            4'b01_01: w_half = CNT_W'(19101);
            4'b01_10: w_half = CNT_W'(16055);
            4'b01_11: w_half = CNT_W'(12022);
            4'b10_00: w_half = CNT_W'(57216);
            4'b10_10: w_half = CNT_W'(57216);
            4'b11_00: w_half = CNT_W'(32111);
            4'b11_01: w_half = CNT_W'(38144);
            4'b11_10: w_half = CNT_W'(48044);
            default:  w_half = '0;
        endcase
    end
    // Edge regs come out of reset set, so a request level held across reset never starts a jingle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_id    <= 2'd0;
            r_note  <= 2'd0;
            r_frame <= '0;
            r_tone  <= '0;
            r_out   <= 1'b0;
            r_eat_q <= 1'b1;
            r_die_q <= 1'b1;
            r_hit_q <= 1'b1;
        end else begin
            r_eat_q <= eat_sound;
            r_die_q <= die_sound;
            r_hit_q <= hit_sound;
            if (w_start) begin
                r_state <= PLAY;
                r_id    <= w_new_id;
                r_note  <= 2'd0;
                r_frame <= '0;
                r_tone  <= '0;
                r_out   <= 1'b0;
            end else if (r_state == PLAY) begin
                if (w_adv) begin
                    r_frame <= '0;
                    r_tone  <= '0;
                    r_out   <= r_out & ~w_rest;
                    if (r_note == 2'd3) begin
                        r_state <= IDLE;
                        r_id    <= 2'd0;
                        r_note  <= 2'd0;
                        r_out   <= 1'b0;
                    end else begin
                        r_note <= r_note + 2'd1;
                    end
                end else begin
                    if (frame_end)
                        r_frame <= r_frame + 1'b1;
                    if (w_rest) begin
                        r_tone <= '0;
                        r_out  <= 1'b0;
                    end else if (r_tone == w_half - CNT_W'(1)) begin
                        r_tone <= '0;
                        r_out  <= ~r_out;
                    end else begin
                        r_tone <= r_tone + CNT_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_apu_sound_player.sv
// tb_apu_sound_player: directed and random stimulus against a note/toggle-count reference model.
module tb_apu_sound_player;
    localparam int NF = 2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       eat = 1'b0, hit = 1'b0, die = 1'b0, fe = 1'b0;
    logic       sound_out, busy;
    logic [1:0] sound_id;
    int n_chk = 0, n_fail = 0;
    int fper = 0, fcnt = 0, cnt = 0;
    bit chk_on = 0;
    int tbl [4][4] = '{'{0, 0, 0, 0},
                       '{24068, 19101, 16055, 12022},
                       '{57216, 0, 57216, 0},
                       '{32111, 38144, 48044, 0}};
    int m_id = 0, m_note = 0, m_frames = 0, m_edges = 0, m_base = 0, nid = 0, h = 0;
    logic pe = 1'b1, ph = 1'b1, pd = 1'b1;

    apu_sound_player #(.NOTE_FRAMES(NF), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_end(fe),
        .eat_sound(eat), .die_sound(die), .hit_sound(hit),
        .sound_out(sound_out), .busy(busy), .sound_id(sound_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: expected level = base XOR parity of completed half-periods within the current note.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_id = 0; m_note = 0; m_frames = 0; m_edges = 0; m_base = 0;
            pe = 1'b1; ph = 1'b1; pd = 1'b1;
        end else begin
            nid = (die && !pd) ? 3 : (hit && !ph) ? 2 : (eat && !pe) ? 1 : 0;
            if (nid > m_id) begin
                m_id = nid; m_note = 0; m_frames = 0; m_edges = 0; m_base = 0;
            end else if (m_id != 0) begin
                m_edges++;
                if (fe) m_frames++;
                if (m_frames == NF) begin
                    h = tbl[m_id][m_note];
                    m_base = (h == 0) ? 0 : (m_base ^ (((m_edges - 1) / h) & 1));
                    if (m_note == 3) m_id = 0; else m_note++;
                    m_frames = 0; m_edges = 0;
                end
            end
            pe = eat; ph = hit; pd = die;
        end
    end

    function automatic int exp_out();
        int hh = tbl[m_id][m_note];
        return (m_id == 0 || hh == 0) ? 0 : (m_base ^ ((m_edges / hh) & 1));
    endfunction

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            check("model_out", {31'd0, sound_out}, exp_out());
            check("model_busy", {31'd0, busy}, (m_id != 0) ? 1 : 0);
            check("model_id", {30'd0, sound_id}, m_id);
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fcnt++;
            if (fper > 0 && fcnt >= fper) begin
                fe = 1'b1;
                fcnt = 0;
            end else begin
                fe = 1'b0;
            end
        end
    endtask

    task automatic set_req(input logic e, input logic hh, input logic d, input logic f);
        @(negedge clk);
        eat = e; hit = hh; die = d; fe = f;
        fcnt = 0;
    endtask

    task automatic wait_fes(input int k);
        int got = 0;
        int t = 0;
        while (got < k && t < 200000) begin
            cyc(1);
            t++;
            if (fe) got++;
        end
        if (got < k) check("fe_timeout", got, k);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 40000) begin
            cyc(1);
            t++;
        end
        check("idle_timeout", {31'd0, busy}, 0);
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        chk_on = 1;
        cyc(2);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_id", {30'd0, sound_id}, 0);
        // reset mid-jingle, eat held across reset
        set_req(1, 0, 0, 0);
        cyc(50);
        check("pre_rst_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 0);
        check("async_rst_id", {30'd0, sound_id}, 0);
        check("async_rst_out", {31'd0, sound_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        check("held_no_start", {31'd0, busy}, 0);
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        cyc(1);
        check("rearm_start", {30'd0, sound_id}, 1);
        eat = 1'b0;
        fper = 200;
        wait_idle();
        // eat jingle: first toggle after exactly one half-period
        fper = 13000;
        set_req(1, 0, 0, 0);
        cyc(1);
        check("eat_busy", {31'd0, busy}, 1);
        check("eat_id", {30'd0, sound_id}, 1);
        eat = 1'b0;
        cnt = 0;
        while (!sound_out && cnt < 30000) begin
            cyc(1);
            cnt++;
        end
        check("eat_half0", cnt, 24068);
        fper = 200;
        wait_idle();
        // simultaneous requests with frame_end on the start cycle
        set_req(1, 1, 1, 1);
        cyc(1);
        check("simul_id", {30'd0, sound_id}, 3);
        eat = 1'b0; hit = 1'b0; die = 1'b0;
        wait_fes(4 * NF - 1);
        cyc(1);
        check("simul_busy_before_end", {31'd0, busy}, 1);
        wait_fes(1);
        cyc(1);
        check("simul_busy_end", {31'd0, busy}, 0);
        check("simul_id_end", {30'd0, sound_id}, 0);
        // hit held past the whole jingle starts exactly once
        set_req(0, 1, 0, 0);
        cyc(1);
        check("hit_id", {30'd0, sound_id}, 2);
        wait_fes(4 * NF);
        cyc(1);
        check("hit_end", {31'd0, busy}, 0);
        wait_fes(3);
        check("hit_no_restart", {31'd0, busy}, 0);
        hit = 1'b0;
        // preemption by die, later hit ignored
        fper = 0;
        set_req(1, 0, 0, 0);
        cyc(100);
        check("pre_eat_id", {30'd0, sound_id}, 1);
        set_req(1, 0, 1, 0);
        cyc(1);
        check("preempt_id", {30'd0, sound_id}, 3);
        check("preempt_out", {31'd0, sound_out}, 0);
        cnt = 0;
        while (!sound_out && cnt < 40000) begin
            cyc(1);
            cnt++;
        end
        check("die_half0", cnt, 32111);
        set_req(1, 1, 1, 0);
        cyc(1);
        check("hit_ignored", {30'd0, sound_id}, 3);
        eat = 1'b0; hit = 1'b0; die = 1'b0;
        fper = 200;
        wait_idle();
        // idle robustness
        fper = 20;
        wait_fes(50);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_out", {31'd0, sound_out}, 0);
        // random requests and frame spacing
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) fper = $urandom_range(3, 30);
            cyc(1);
            if ($urandom_range(0, 63) == 0) eat = ~eat;
            if ($urandom_range(0, 63) == 0) hit = ~hit;
            if ($urandom_range(0, 95) == 0) die = ~die;
        end
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
